// File: rtl/turn_signal_ctrl_if.sv
// ---------------------------------------------------------------------------
// turn_signal_ctrl_if
//
// Purpose:
//   Groups the car-side inputs and the lamp-side outputs of the turn/hazard
//   indicator controller into a single bundle. Clock and reset are not part of
//   the bundle; they stay as plain ports on the controller.
//
// Signals:
//   power_now   car -> ctrl   high forces all lamps off and the FSM to S_OFF
//   state[3:0]  car -> ctrl   one-hot car state (0001 unstarting, 0010 starting,
//                             0100 moving, 1000 power_off)
//   answer[3:0] car -> ctrl   [3] left, [2] right, [1] back, [0] forward
//   hazard      car -> ctrl   hazard switch, level-sensitive
//   left_led    ctrl -> car   left lamp bank, LAMPS wide
//   right_led   ctrl -> car   right lamp bank, LAMPS wide
//   active_dir  ctrl -> car   00 none, 01 left, 10 right, 11 hazard
//
// Modports:
//   master  drives the car-side inputs (car logic or a testbench)
//   slave   the indicator controller itself
// ---------------------------------------------------------------------------
interface turn_signal_ctrl_if #(
   parameter int LAMPS = 3
);

   logic             power_now;
   logic [3:0]       state;
   logic [3:0]       answer;
   logic             hazard;
   logic [LAMPS-1:0] left_led;
   logic [LAMPS-1:0] right_led;
   logic [1:0]       active_dir;

   modport master (
      output power_now,
      output state,
      output answer,
      output hazard,
      input  left_led,
      input  right_led,
      input  active_dir
   );

   modport slave (
      input  power_now,
      input  state,
      input  answer,
      input  hazard,
      output left_led,
      output right_led,
      output active_dir
   );

endinterface

// File: rtl/turn_signal_ctrl.sv
// ---------------------------------------------------------------------------
// turn_signal_ctrl
//
// Purpose:
//   Turn and hazard indicator controller. Drives LAMPS lamps per side from an
//   internal blink timer that is phase-aligned to the moment a direction or
//   hazard request is accepted, so the first flash always gets a full on-half.
//   A released turn request keeps flashing until MIN_BLINKS flashes have
//   completed; an opposite request cancels the current direction at once.
//
// Parameters:
//   LAMPS        lamps per side (>= 1)
//   HALF_PERIOD  clk cycles per on-half and per off-half (>= 2; >= LAMPS when
//                the sweep build is used)
//   MIN_BLINKS   completed flashes required before a released turn may end
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   turn_signal_ctrl_if.slave (power_now, state, answer, hazard in;
//         left_led, right_led, active_dir out)
//
// Build option:
//   SEQ_SWEEP_EN  when defined, the on-half lights the bank cumulatively from
//                 the inner lamp (bit 0) outwards; when undefined the whole
//                 bank switches together. Timer, FSM and latency are the same.
// ---------------------------------------------------------------------------
module turn_signal_ctrl #(
   parameter int LAMPS       = 3,
   parameter int HALF_PERIOD = 50_000_000,
   parameter int MIN_BLINKS  = 3
) (
   input logic               clk,
   input logic               rst,
   turn_signal_ctrl_if.slave bus
);

   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int BW = (MIN_BLINKS > 0) ? $clog2(MIN_BLINKS + 1) : 1;

   localparam logic [CW-1:0] CNT_MAX  = CW'(HALF_PERIOD - 1);
   localparam logic [BW-1:0] BLINK_MIN = BW'(MIN_BLINKS);

   typedef enum logic [2:0] {
      S_OFF,
      S_IDLE,
      S_LEFT,
      S_RIGHT,
      S_HAZARD
   } fsmState_e;

   fsmState_e        fsmState_q, fsmState_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [BW-1:0]    blinkCnt_q, blinkCnt_d;
   logic [LAMPS-1:0] leftLed_q, leftLed_d;
   logic [LAMPS-1:0] rightLed_q, rightLed_d;
   logic [1:0]       activeDir_q, activeDir_d;

   logic             carEnabled;
   logic             wantLeft;
   logic             wantRight;
   logic             minBlinksDone;
   logic             blinkingNext;
   logic             entering;
   logic [LAMPS-1:0] bankOn;
   logic             unused_answer;

   // Only the left/right bits of the direction bus matter to the indicators.
   assign unused_answer = &{1'b0, bus.answer[1:0]};

   // The indicators may only run while the car is starting or moving.
   assign carEnabled = (bus.state == 4'b0010) || (bus.state == 4'b0100);

   // A request for one side counts only when the other side is not also
   // requested; both together is treated as no new request.
   assign wantLeft  = bus.answer[3] & ~bus.answer[2];
   assign wantRight = bus.answer[2] & ~bus.answer[3];

   // A released turn may end only at the start of an off-half, once enough
   // flashes have completed, so the last flash is never cut short.
   assign minBlinksDone = (phase_q == 1'b0) && (blinkCnt_q >= BLINK_MIN);

   // State register for the indicator FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsmState_q <= S_OFF;
      end else begin
         fsmState_q <= fsmState_d;
      end
   end

   // Next-state logic. The override chain (power, hazard, car disabled) is
   // checked before any per-state behaviour, so hazard works even with the car
   // not started, and losing enable drops a turn without the min-blink hold.
   always_comb begin
      fsmState_d = fsmState_q;
      if (bus.power_now) begin
         fsmState_d = S_OFF;
      end else if (bus.hazard) begin
         fsmState_d = S_HAZARD;
      end else if (!carEnabled) begin
         fsmState_d = S_OFF;
      end else begin
         unique case (fsmState_q)
            S_OFF: begin
               fsmState_d = S_IDLE;
            end
            S_IDLE: begin
               if (wantLeft) begin
                  fsmState_d = S_LEFT;
               end else if (wantRight) begin
                  fsmState_d = S_RIGHT;
               end
            end
            S_LEFT: begin
               if (wantRight) begin
                  fsmState_d = S_RIGHT;
               end else if (!bus.answer[3] && minBlinksDone) begin
                  fsmState_d = S_IDLE;
               end
            end
            S_RIGHT: begin
               if (wantLeft) begin
                  fsmState_d = S_LEFT;
               end else if (!bus.answer[2] && minBlinksDone) begin
                  fsmState_d = S_IDLE;
               end
            end
            S_HAZARD: begin
               // Hazard has just been released while the car is enabled.
               fsmState_d = S_IDLE;
            end
            default: begin
               fsmState_d = S_OFF;
            end
         endcase
      end
   end

   // Timer state: half-period counter, current phase and completed flashes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         blinkCnt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         blinkCnt_q <= blinkCnt_d;
      end
   end

   // The timer follows the state being entered. Any entry into a blinking
   // state, including a direct left/right swap or turn-to-hazard, restarts the
   // timer in the on-half so the new pattern begins with a full clean flash.
   always_comb begin
      cnt_d        = cnt_q;
      phase_d      = phase_q;
      blinkCnt_d   = blinkCnt_q;
      blinkingNext = (fsmState_d == S_LEFT) || (fsmState_d == S_RIGHT) ||
                     (fsmState_d == S_HAZARD);
      entering     = blinkingNext && (fsmState_d != fsmState_q);
      if (!blinkingNext) begin
         cnt_d      = '0;
         phase_d    = 1'b0;
         blinkCnt_d = '0;
      end else if (entering) begin
         cnt_d      = '0;
         phase_d    = 1'b1;
         blinkCnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
         // A flash is complete when its on-half ends.
         if (phase_q && (blinkCnt_q < BLINK_MIN)) begin
            blinkCnt_d = blinkCnt_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Lamp pattern of one bank while its side is active.
`ifdef SEQ_SWEEP_EN
   // Lamp i joins once the counter reaches i steps into the on-half; the
   // inner lamp is lit for the whole on-half.
   localparam int SWEEP_STEP = HALF_PERIOD / LAMPS;
   logic [LAMPS-1:0] sweepMask;
   for (genvar i = 0; i < LAMPS; i++) begin : g_sweep
      if (i == 0) begin : g_inner
         assign sweepMask[i] = 1'b1;
      end else begin : g_outer
         localparam logic [CW-1:0] THRESHOLD = CW'(i * SWEEP_STEP);
         assign sweepMask[i] = (cnt_q >= THRESHOLD);
      end
   end
   assign bankOn = phase_q ? sweepMask : '0;
`else
   assign bankOn = {LAMPS{phase_q}};
`endif

   // Output decode. Lamps follow the registered FSM and timer, which puts them
   // one clock behind a state change; active_dir follows the next state so it
   // updates on the same edge as the FSM. power_now blanks the lamps at once.
   always_comb begin
      leftLed_d   = '0;
      rightLed_d  = '0;
      activeDir_d = 2'b00;
      unique case (fsmState_q)
         S_LEFT:   leftLed_d = bankOn;
         S_RIGHT:  rightLed_d = bankOn;
         S_HAZARD: begin
            leftLed_d  = bankOn;
            rightLed_d = bankOn;
         end
         default: begin
            leftLed_d  = '0;
            rightLed_d = '0;
         end
      endcase
      if (bus.power_now) begin
         leftLed_d  = '0;
         rightLed_d = '0;
      end
      unique case (fsmState_d)
         S_LEFT:   activeDir_d = 2'b01;
         S_RIGHT:  activeDir_d = 2'b10;
         S_HAZARD: activeDir_d = 2'b11;
         default:  activeDir_d = 2'b00;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         leftLed_q   <= '0;
         rightLed_q  <= '0;
         activeDir_q <= 2'b00;
      end else begin
         leftLed_q   <= leftLed_d;
         rightLed_q  <= rightLed_d;
         activeDir_q <= activeDir_d;
      end
   end

   assign bus.left_led   = leftLed_q;
   assign bus.right_led  = rightLed_q;
   assign bus.active_dir = activeDir_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_ctrl
//
// Directed bench for turn_signal_ctrl with LAMPS=3, HALF_PERIOD=4,
// MIN_BLINKS=2 in the default (non-sweep) build. Inputs change and outputs are
// observed 1 time unit after a rising clock edge.
// ---------------------------------------------------------------------------
module tb_turn_signal_ctrl;

   localparam int LAMPS       = 3;
   localparam int HALF_PERIOD = 4;
   localparam int MIN_BLINKS  = 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   turn_signal_ctrl_if #(.LAMPS(LAMPS)) bus ();

   turn_signal_ctrl #(
      .LAMPS      (LAMPS),
      .HALF_PERIOD(HALF_PERIOD),
      .MIN_BLINKS (MIN_BLINKS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n rising edges and settle just past the last one.
   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive all car-side inputs at once.
   task automatic applyStimulus(input logic pwr, input logic [3:0] st,
                                input logic [3:0] ans, input logic haz);
      bus.power_now = pwr;
      bus.state     = st;
      bus.answer    = ans;
      bus.hazard    = haz;
   endtask

   // Compare all three outputs against hand-computed values.
   task automatic checkOutput(input string tag, input logic [2:0] expLeft,
                              input logic [2:0] expRight, input logic [1:0] expDir);
      checks++;
      assert (bus.left_led === expLeft) else begin
         errors++;
         $error("[TB] FAIL %s left_led got %b expected %b", tag, bus.left_led, expLeft);
      end
      checks++;
      assert (bus.right_led === expRight) else begin
         errors++;
         $error("[TB] FAIL %s right_led got %b expected %b", tag, bus.right_led, expRight);
      end
      checks++;
      assert (bus.active_dir === expDir) else begin
         errors++;
         $error("[TB] FAIL %s active_dir got %b expected %b", tag, bus.active_dir, expDir);
      end
   endtask

   // Directed sequence; every expected value below is traced by hand from the
   // edge at which the FSM changes (lamps follow one edge later).
   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      applyStimulus(1'b0, 4'b0100, 4'b1000, 1'b0);

      // Reset held with a left request pending: everything dark.
      ticks(2);
      checkOutput("reset", 3'b000, 3'b000, 2'b00);

      // Release reset: OFF -> IDLE -> LEFT, then 4 on / 4 off.
      rst = 1'b0;
      ticks(1);
      checkOutput("offToIdle", 3'b000, 3'b000, 2'b00);
      ticks(1);
      checkOutput("enterLeft", 3'b000, 3'b000, 2'b01);
      ticks(1);
      checkOutput("leftOnFirst", 3'b111, 3'b000, 2'b01);
      ticks(3);
      checkOutput("leftOnLast", 3'b111, 3'b000, 2'b01);
      ticks(1);
      checkOutput("leftOffFirst", 3'b000, 3'b000, 2'b01);
      ticks(3);
      checkOutput("leftOffLast", 3'b000, 3'b000, 2'b01);
      ticks(1);
      checkOutput("leftOnAgain", 3'b111, 3'b000, 2'b01);

      // Car goes unstarting mid-flash: FSM drops at once, lamps one edge later.
      applyStimulus(1'b0, 4'b0001, 4'b1000, 1'b0);
      ticks(1);
      checkOutput("disableLag", 3'b111, 3'b000, 2'b00);
      ticks(1);
      checkOutput("disableDark", 3'b000, 3'b000, 2'b00);

      // One-cycle left pulse: exactly two full flashes, then back to idle.
      applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
      ticks(1);
      applyStimulus(1'b0, 4'b0100, 4'b1000, 1'b0);
      ticks(1);
      checkOutput("pulseEnter", 3'b000, 3'b000, 2'b01);
      applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
      ticks(1);
      checkOutput("pulseFlash1On", 3'b111, 3'b000, 2'b01);
      ticks(3);
      checkOutput("pulseFlash1End", 3'b111, 3'b000, 2'b01);
      ticks(1);
      checkOutput("pulseHeldOff", 3'b000, 3'b000, 2'b01);
      ticks(4);
      checkOutput("pulseFlash2On", 3'b111, 3'b000, 2'b01);
      ticks(3);
      checkOutput("pulseFlash2End", 3'b111, 3'b000, 2'b01);
      ticks(1);
      checkOutput("pulseExit", 3'b000, 3'b000, 2'b00);
      ticks(4);
      checkOutput("pulseNoThird", 3'b000, 3'b000, 2'b00);

      // Left to right switch in the middle of an on-half.
      applyStimulus(1'b0, 4'b0100, 4'b1000, 1'b0);
      ticks(1);
      checkOutput("swEnterLeft", 3'b000, 3'b000, 2'b01);
      ticks(1);
      checkOutput("swLeftOn", 3'b111, 3'b000, 2'b01);
      applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
      ticks(1);
      checkOutput("swDirFirst", 3'b111, 3'b000, 2'b10);
      ticks(1);
      checkOutput("swRightOn", 3'b000, 3'b111, 2'b10);
      ticks(3);
      checkOutput("swRightOnLast", 3'b000, 3'b111, 2'b10);
      ticks(1);
      checkOutput("swRightOff", 3'b000, 3'b000, 2'b10);
      ticks(4);
      checkOutput("swRightOnAgain", 3'b000, 3'b111, 2'b10);

      // Car powers off while right is lit: dark within two edges.
      applyStimulus(1'b0, 4'b1000, 4'b0100, 1'b0);
      ticks(1);
      checkOutput("pwrOffLag", 3'b000, 3'b111, 2'b00);
      ticks(1);
      checkOutput("pwrOffDark", 3'b000, 3'b000, 2'b00);

      // Both directions requested from idle: nothing lights.
      applyStimulus(1'b0, 4'b0100, 4'b1100, 1'b0);
      ticks(6);
      checkOutput("bothDirs", 3'b000, 3'b000, 2'b00);

      // Hazard while unstarting: both banks 4 on / 4 off.
      applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
      ticks(1);
      checkOutput("hazEnter", 3'b000, 3'b000, 2'b11);
      ticks(1);
      checkOutput("hazOn", 3'b111, 3'b111, 2'b11);
      ticks(3);
      checkOutput("hazOnLast", 3'b111, 3'b111, 2'b11);
      ticks(1);
      checkOutput("hazOff", 3'b000, 3'b000, 2'b11);
      ticks(4);
      checkOutput("hazOnAgain", 3'b111, 3'b111, 2'b11);

      // power_now overrides hazard and blanks the lamps on the next edge.
      applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1);
      ticks(1);
      checkOutput("powerNow", 3'b000, 3'b000, 2'b00);
      ticks(1);
      checkOutput("powerNowHeld", 3'b000, 3'b000, 2'b00);
      applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0);
      ticks(3);
      checkOutput("unstartedIdle", 3'b000, 3'b000, 2'b00);

      // Asynchronous reset in the middle of a hazard on-half.
      applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
      ticks(3);
      checkOutput("hazBeforeRst", 3'b111, 3'b111, 2'b11);
      rst = 1'b1;
      #2;
      checkOutput("asyncReset", 3'b000, 3'b000, 2'b00);
      ticks(2);
      checkOutput("resetHeld", 3'b000, 3'b000, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
